// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding an 8N1-style UART serialiser
// with configurable data bits, parity and stop bits.
//
// Ports:
//   sys_clk    - single rising-edge clock
//   sys_rst    - asynchronous active-high reset; aborts any frame, empties the FIFO
//   s_data     - byte to send; only [DATA_BITS-1:0] reach the line
//   s_valid    - s_data valid; accepted when s_ready is also high
//   s_ready    - FIFO not full
//   tx         - registered serial line, idle high
//   tx_busy    - frame in progress or FIFO non-empty
//   fifo_count - current FIFO occupancy
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [7:0]        DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic              ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic       push, pop, start_frame, bit_end, fifo_empty;
    logic [7:0] head;

    assign fifo_empty = (count_q == '0);
    assign s_ready    = (count_q < CNT_W'(FIFO_DEPTH));
    assign push       = s_valid & s_ready;
    assign head       = mem[rd_ptr_q] & DATA_MASK;
    assign bit_end    = (baud_q == BAUD_LAST);

    assign tx         = tx_q;
    assign tx_busy    = (state_q != StIdle) | ~fifo_empty;
    assign fifo_count = count_q;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d      = '0;
                bit_d       = '0;
                tx_d        = 1'b1;
                start_frame = ~fifo_empty;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                            bit_d   = '0;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Pop the head byte and drive the start bit on this same edge.
        if (start_frame) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = (^head) ^ ODD_PAR;
            tx_d     = 1'b0;
            baud_d   = '0;
            bit_d    = '0;
            state_d  = StStart;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five parameter sets side by side, each with a
// timeline model (queue of pending frames, start time, bit lookup), plus
// hand-computed frame patterns and lengths.
module tb_uart_tx_fifo;

    localparam int NCFG = 5;
    localparam int unsigned P_CF   [NCFG] = '{50_000_000, 50_000_000, 50_000_000, 50_000_000,
                                              1_000_000};
    localparam int unsigned P_BAUD [NCFG] = '{115200, 115200, 115200, 115200, 100_000};
    localparam int unsigned P_DB   [NCFG] = '{8, 8, 8, 7, 8};
    localparam int unsigned P_PAR  [NCFG] = '{0, 1, 2, 0, 0};
    localparam int unsigned P_SB   [NCFG] = '{1, 1, 1, 2, 1};
    localparam int unsigned P_DEP  [NCFG] = '{16, 16, 16, 16, 4};

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [7:0]      sd = '0;
    logic [NCFG-1:0] sv = '0;

    wire [NCFG-1:0]      d_tx, d_busy, d_rdy, m_tx, m_busy, m_rdy;
    wire [NCFG-1:0][7:0] d_cnt, m_cnt;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned CPB  = P_CF[g] / P_BAUD[g];
        localparam int unsigned DB   = P_DB[g];
        localparam int unsigned PAR  = P_PAR[g];
        localparam int unsigned SB   = P_SB[g];
        localparam int unsigned DEP  = P_DEP[g];
        localparam int unsigned FLEN = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CPB;

        logic [$clog2(DEP):0] cnt;

        uart_tx_fifo #(
            .CLK_FREQ  (P_CF[g]),
            .BAUD      (P_BAUD[g]),
            .DATA_BITS (DB),
            .PARITY    (PAR),
            .STOP_BITS (SB),
            .FIFO_DEPTH(DEP)
        ) u_dut (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .s_data    (sd),
            .s_valid   (sv[g]),
            .s_ready   (d_rdy[g]),
            .tx        (d_tx[g]),
            .tx_busy   (d_busy[g]),
            .fifo_count(cnt)
        );
        assign d_cnt[g] = 8'(cnt);

        // Line bits of a whole frame, bit 0 first on the wire.
        function automatic logic [11:0] frame_of(input logic [7:0] b);
            logic [11:0] f;
            int ones;
            f    = '1;
            f[0] = 1'b0;
            ones = 0;
            for (int i = 0; i < int'(DB); i++) begin
                f[i + 1] = b[i];
                ones += int'(b[i]);
            end
            if (PAR == 1) f[DB + 1] = (ones % 2 == 1);
            else if (PAR == 2) f[DB + 1] = (ones % 2 == 0);
            return f;
        endfunction

        logic [11:0] pend [$];
        logic [11:0] cur = '1;
        longint      e = 0, t0 = 0, free_at = 0;
        logic        e_tx = 1'b1, e_busy = 1'b0;
        int          e_cnt = 0;

        initial forever begin
            logic acc;
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) begin
                pend.delete();
                free_at = 0;
                e_tx    = 1'b1;
                e_busy  = 1'b0;
                e_cnt   = 0;
            end else begin
                e++;
                acc = sv[g] && (pend.size() < int'(DEP));
                if (e >= free_at && pend.size() > 0) begin
                    cur     = pend.pop_front();
                    t0      = e;
                    free_at = e + longint'(FLEN);
                end
                if (acc) pend.push_back(frame_of(sd));
                e_tx   = (e < free_at) ? cur[int'((e - t0) / longint'(CPB))] : 1'b1;
                e_busy = (e < free_at) || (pend.size() > 0);
                e_cnt  = pend.size();
            end
        end

        assign m_tx[g]   = e_tx;
        assign m_busy[g] = e_busy;
        assign m_cnt[g]  = 8'(e_cnt);
        assign m_rdy[g]  = (e_cnt < int'(DEP));
    end

    task automatic check(input string what, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", what, c, act, exp, $time);
        end
    endtask

    // Advance one clock and compare every instance against its model.
    task automatic tick();
        @(negedge sys_clk);
        for (int i = 0; i < NCFG; i++) begin
            check("tx", i, 32'(d_tx[i]), 32'(m_tx[i]));
            check("tx_busy", i, 32'(d_busy[i]), 32'(m_busy[i]));
            check("s_ready", i, 32'(d_rdy[i]), 32'(m_rdy[i]));
            check("fifo_count", i, 32'(d_cnt[i]), 32'(m_cnt[i]));
        end
    endtask

    task automatic push(input int c, input logic [7:0] b);
        sd    = b;
        sv[c] = 1'b1;
        tick();
        sv[c] = 1'b0;
    endtask

    // Count samples until tx_busy drops; grab tx mid-bit for the first 12 bits.
    task automatic run_frames(input int c, output int len, output logic [11:0] samp);
        int cpb;
        cpb  = int'(P_CF[c] / P_BAUD[c]);
        samp = '1;
        len  = 0;
        while (d_busy[c] === 1'b1 && len < 40000) begin
            if (len % cpb == cpb / 2 && len / cpb < 12) samp[len / cpb] = d_tx[c];
            len++;
            tick();
        end
        check("drain_in_time", c, 32'(len < 40000), 32'd1);
    endtask

    task automatic send_one(input int c, input logic [7:0] b, output int len,
                            output logic [11:0] samp);
        push(c, b);
        check("busy_after_accept", c, 32'(d_busy[c]), 32'd1);
        check("count_after_accept", c, 32'(d_cnt[c]), 32'd1);
        tick();
        check("tx_fall_latency", c, 32'(d_tx[c]), 32'd0);
        run_frames(c, len, samp);
    endtask

    initial begin
        int          len;
        logic [11:0] samp;

        repeat (3) tick();
        check("rst_tx", 0, 32'(d_tx[0]), 32'd1);
        check("rst_ready", 0, 32'(d_rdy[0]), 32'd1);
        check("rst_busy", 0, 32'(d_busy[0]), 32'd0);
        check("rst_count", 0, 32'(d_cnt[0]), 32'd0);
        sys_rst = 1'b0;
        tick();

        // 8N1, 0x55
        send_one(0, 8'h55, len, samp);
        check("len_8n1", 0, 32'(len), 32'd4340);
        check("bits_0x55", 0, 32'(samp[9:0]), 32'h2AA);
        // even / odd parity on 0x07
        send_one(1, 8'h07, len, samp);
        check("len_8e1", 1, 32'(len), 32'd4774);
        check("bits_even", 1, 32'(samp[10:0]), 32'h60E);
        send_one(2, 8'h07, len, samp);
        check("len_8o1", 2, 32'(len), 32'd4774);
        check("bits_odd", 2, 32'(samp[10:0]), 32'h40E);
        // 7 data bits, 2 stop bits, bit 7 dropped
        send_one(3, 8'hFF, len, samp);
        check("len_7n2", 3, 32'(len), 32'd4340);
        check("bits_7n2", 3, 32'(samp[10:0]), 32'h7FE);

        // Depth-4 burst: first pops at once, four fill, sixth rejected.
        push(4, 8'hA1);
        push(4, 8'hA2);
        push(4, 8'hA3);
        push(4, 8'hA4);
        push(4, 8'hA5);
        check("full_count", 4, 32'(d_cnt[4]), 32'd4);
        check("full_ready", 4, 32'(d_rdy[4]), 32'd0);
        push(4, 8'hA6);
        check("reject_count", 4, 32'(d_cnt[4]), 32'd4);
        run_frames(4, len, samp);
        check("burst_len", 4, 32'(len), 32'd496);

        // Push coinciding with stop-end pop, then a push while full at a pop.
        push(4, 8'hB1);
        push(4, 8'hB2);
        push(4, 8'hB3);
        push(4, 8'hB4);
        check("queued_count", 4, 32'(d_cnt[4]), 32'd3);
        repeat (97) tick();
        check("pre_pop_count", 4, 32'(d_cnt[4]), 32'd3);
        push(4, 8'hB5);
        check("push_pop_count", 4, 32'(d_cnt[4]), 32'd3);
        check("no_gap_start", 4, 32'(d_tx[4]), 32'd0);
        push(4, 8'hB6);
        check("refull_ready", 4, 32'(d_rdy[4]), 32'd0);
        repeat (98) tick();
        push(4, 8'hB7);
        check("full_pop_count", 4, 32'(d_cnt[4]), 32'd3);
        run_frames(4, len, samp);
        check("drain_len", 4, 32'(len), 32'd400);

        // Reset during data bit 3 with three bytes queued.
        push(0, 8'h00);
        push(0, 8'h3C);
        push(0, 8'hC3);
        push(0, 8'h5A);
        check("pre_reset_count", 0, 32'(d_cnt[0]), 32'd3);
        repeat (1934) tick();
        check("pre_reset_tx", 0, 32'(d_tx[0]), 32'd0);
        sys_rst = 1'b1;
        #1;
        check("async_rst_tx", 0, 32'(d_tx[0]), 32'd1);
        check("async_rst_count", 0, 32'(d_cnt[0]), 32'd0);
        check("async_rst_ready", 0, 32'(d_rdy[0]), 32'd1);
        check("async_rst_busy", 0, 32'(d_busy[0]), 32'd0);
        tick();
        tick();
        sys_rst = 1'b0;
        repeat (3000) tick();
        check("post_rst_tx", 0, 32'(d_tx[0]), 32'd1);
        check("post_rst_busy", 0, 32'(d_busy[0]), 32'd0);
        send_one(0, 8'hA5, len, samp);
        check("len_after_rst", 0, 32'(len), 32'd4340);
        check("bits_0xa5", 0, 32'(samp[9:0]), 32'h34A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
